// File: rtl/sdrc_responder.sv
// sdrc_responder: block-RAM stand-in for the SDRAM controller user port (init, ack, bursts, dqm, page wrap).
// Optional macro SDRC_RESPONDER_CHECK_EN adds open-row tracking and the sticky protocol_error flag.
module sdrc_responder #(
    parameter int DepthBitWidth = 12,
    parameter int InitCycles    = 16,
    parameter int CasLatency    = 2,
    parameter int RefreshCycles = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_sdrc_cmd_en,
    input  logic [2:0]  I_sdrc_cmd,
    input  logic        I_sdrc_precharge_ctrl,
    input  logic        I_sdram_power_down,
    input  logic        I_sdram_selfrefresh,
    input  logic [20:0] I_sdrc_addr,
    input  logic [3:0]  I_sdrc_dqm,
    input  logic [31:0] I_sdrc_data,
    input  logic [7:0]  I_sdrc_data_len,
    output logic [31:0] O_sdrc_data,
    output logic        O_sdrc_init_done,
    output logic        O_sdrc_cmd_ack,
    output logic        protocol_error
);
    // state          | meaning
    // ST_INIT        | post-reset wait, init_done low
    // ST_IDLE        | ready to accept a command
    // ST_ACK         | cmd_ack high; write beat 0 sampled here
    // ST_WRITE_BURST | write beats 1..data_len
    // ST_READ_LAT    | CAS latency wait before first read beat
    // ST_READ_BURST  | read beat visible on O_sdrc_data
    // ST_REFRESH     | refresh delay before ack

    localparam logic [2:0] CMD_ACTIVATE  = 3'b011;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_NOP       = 3'b111;
    localparam int         CAS_WAIT      = (CasLatency >= 2) ? CasLatency - 2 : 0;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACK,
        ST_WRITE_BURST,
        ST_READ_LAT,
        ST_READ_BURST,
        ST_REFRESH
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [15:0]              r_cnt;
    logic [2:0]               r_cmd;
    logic [12:0]              r_row_sel;
    logic [7:0]               r_col;
    logic [7:0]               r_rem;
    logic [31:0]              r_mem [2**DepthBitWidth];
    logic                     w_cmd_valid;
    logic                     w_accept;
    logic                     w_wr_en;
    logic                     w_rd_en;
    logic [20:0]              w_full;
    logic [DepthBitWidth-1:0] w_idx;
    logic                     w_unused;

    assign w_full           = {r_row_sel, r_col};
    assign w_idx            = w_full[DepthBitWidth-1:0];
    assign w_unused         = ^{I_sdrc_precharge_ctrl, w_full};
    assign O_sdrc_init_done = (r_state != ST_INIT);
    assign O_sdrc_cmd_ack   = (r_state == ST_ACK);

    always_comb begin
        w_cmd_valid = 1'b0;
        case (I_sdrc_cmd)
            CMD_ACTIVATE, CMD_READ, CMD_WRITE, CMD_REFRESH, CMD_PRECHARGE: w_cmd_valid = 1'b1;
            default: w_cmd_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_wr_en  = 1'b0;
        w_rd_en  = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == '0) w_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (I_sdrc_cmd_en && !I_sdram_power_down && !I_sdram_selfrefresh && w_cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = (I_sdrc_cmd == CMD_REFRESH) ? ST_REFRESH : ST_ACK;
                end
            end
            ST_REFRESH: begin
                if (r_cnt == '0) w_next = ST_ACK;
            end
            ST_ACK: begin
                case (r_cmd)
                    CMD_WRITE: begin
                        w_wr_en = 1'b1;
                        w_next  = (r_rem == '0) ? ST_IDLE : ST_WRITE_BURST;
                    end
                    CMD_READ: begin
                        // RAM read latency is one cycle, so the first fetch is issued one cycle early
                        if (CasLatency == 1) begin
                            w_rd_en = 1'b1;
                            w_next  = ST_READ_BURST;
                        end else begin
                            w_next = ST_READ_LAT;
                        end
                    end
                    default: w_next = ST_IDLE;
                endcase
            end
            ST_WRITE_BURST: begin
                w_wr_en = 1'b1;
                if (r_rem == 8'd1) w_next = ST_IDLE;
            end
            ST_READ_LAT: begin
                if (r_cnt == '0) begin
                    w_rd_en = 1'b1;
                    w_next  = ST_READ_BURST;
                end
            end
            ST_READ_BURST: begin
                if (r_rem == '0) w_next = ST_IDLE;
                else w_rd_en = 1'b1;
            end
            default: w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 16'(InitCycles - 1);
            r_cmd       <= CMD_NOP;
            r_row_sel   <= '0;
            r_col       <= '0;
            r_rem       <= '0;
            O_sdrc_data <= '0;
        end else begin
            if (w_accept) begin
                r_cmd     <= I_sdrc_cmd;
                r_row_sel <= I_sdrc_addr[20:8];
                r_col     <= I_sdrc_addr[7:0];
                r_rem     <= I_sdrc_data_len;
            end else if (w_wr_en || w_rd_en) begin
                r_col <= r_col + 8'd1;
            end
            if (w_accept && I_sdrc_cmd == CMD_REFRESH) begin
                r_cnt <= 16'(RefreshCycles - 1);
            end else if (r_state == ST_ACK && r_cmd == CMD_READ) begin
                r_cnt <= 16'(CAS_WAIT);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if (r_state == ST_WRITE_BURST || (r_state == ST_READ_BURST && w_rd_en)) begin
                r_rem <= r_rem - 8'd1;
            end
            if (w_rd_en) O_sdrc_data <= r_mem[w_idx];
        end
    end

    // Reset gates the write so an aborted burst leaves the remaining words untouched
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (!I_sdrc_dqm[b]) r_mem[w_idx][8*b +: 8] <= I_sdrc_data[8*b +: 8];
            end
        end
    end

`ifdef SDRC_RESPONDER_CHECK_EN
    logic [3:0] r_bank_open;
    logic       r_perr;
    logic [1:0] w_bank_in;

    assign w_bank_in = I_sdrc_addr[20:19];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_open <= '0;
            r_perr      <= 1'b0;
        end else begin
            if (I_sdrc_cmd_en && r_state != ST_IDLE) r_perr <= 1'b1;
            if (w_accept) begin
                if ((I_sdrc_cmd == CMD_READ || I_sdrc_cmd == CMD_WRITE) && !r_bank_open[w_bank_in]) r_perr <= 1'b1;
                if (I_sdrc_cmd == CMD_ACTIVATE && r_bank_open[w_bank_in]) r_perr <= 1'b1;
            end
            if (r_state == ST_ACK && r_cmd == CMD_ACTIVATE) r_bank_open[r_row_sel[12:11]] <= 1'b1;
            if (r_state == ST_ACK && r_cmd == CMD_PRECHARGE) r_bank_open[r_row_sel[12:11]] <= 1'b0;
        end
    end

    assign protocol_error = r_perr;
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_sdrc_responder.sv
// Self-checking bench for sdrc_responder: command table plus hand-written reset/protocol sequences.
module tb_sdrc_responder;
    localparam int INIT_CYC = 16;
    localparam int CAS_LAT  = 2;
    localparam int REF_CYC  = 4;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [20:0] ROW5  = 21'h000500;
    localparam logic [20:0] BANK1 = 21'h080000;
`ifdef SDRC_RESPONDER_CHECK_EN
    localparam logic EXP_PERR = 1'b1;
`else
    localparam logic EXP_PERR = 1'b0;
`endif

    typedef struct {
        logic [2:0]  cmd;
        logic [20:0] addr;
        logic [7:0]  len;
        logic [31:0] dbase;
        logic [3:0]  dqm;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cmd_en = 1'b0;
    logic [2:0]  i_cmd = C_NOP;
    logic        i_pc = 1'b0;
    logic        i_pd = 1'b0;
    logic        i_sr = 1'b0;
    logic [20:0] i_addr = '0;
    logic [3:0]  i_dqm = '0;
    logic [31:0] i_data = '0;
    logic [7:0]  i_len = '0;
    logic [31:0] o_data;
    logic        o_init_done;
    logic        o_ack;
    logic        o_perr;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model [int];
    logic [31:0] sb_q [$];
    vec_t        tbl [13];

    sdrc_responder dut (
        .clk                   (clk),
        .rst                   (rst),
        .I_sdrc_cmd_en         (i_cmd_en),
        .I_sdrc_cmd            (i_cmd),
        .I_sdrc_precharge_ctrl (i_pc),
        .I_sdram_power_down    (i_pd),
        .I_sdram_selfrefresh   (i_sr),
        .I_sdrc_addr           (i_addr),
        .I_sdrc_dqm            (i_dqm),
        .I_sdrc_data           (i_data),
        .I_sdrc_data_len       (i_len),
        .O_sdrc_data           (o_data),
        .O_sdrc_init_done      (o_init_done),
        .O_sdrc_cmd_ack        (o_ack),
        .protocol_error        (o_perr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int midx(input logic [20:0] addr, input int k);
        logic [7:0]  col;
        logic [20:0] full;
        col  = addr[7:0] + 8'(k);
        full = {addr[20:8], col};
        return int'(full[11:0]);
    endfunction

    task automatic model_write(input logic [20:0] addr, input int k, input logic [31:0] d, input logic [3:0] dqm);
        logic [31:0] w;
        int          ix;
        ix = midx(addr, k);
        w  = model.exists(ix) ? model[ix] : 32'hxxxxxxxx;
        for (int b = 0; b < 4; b++) begin
            if (!dqm[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        model[ix] = w;
    endtask

    task automatic reset_and_init(input string name);
        int n;
        bit quiet;
        n     = 0;
        quiet = 1'b1;
        rst      = 1'b1;
        i_cmd_en = 1'b0;
        @(negedge clk);
        check({name, "_rst_init_done"}, 32'(o_init_done), 32'd0);
        check({name, "_rst_data"}, o_data, 32'd0);
        check({name, "_rst_perr"}, 32'(o_perr), 32'd0);
        rst = 1'b0;
        while (!o_init_done && n < 40) begin
            @(negedge clk);
            n++;
            if (!o_init_done && (o_ack || o_data != 32'd0 || o_perr)) quiet = 1'b0;
        end
        check({name, "_init_cycles"}, 32'(n), 32'(INIT_CYC));
        check({name, "_quiet_before_init"}, 32'(quiet), 32'd1);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_cmd(input string name, input logic [2:0] cmd, input logic [20:0] addr,
                           input logic [7:0] len, input logic [31:0] dbase, input logic [3:0] dqm,
                           input int exp_lat, input bit chk_data);
        int          lat;
        int          limit;
        bit          got;
        logic [31:0] last;
        lat   = 0;
        got   = 1'b0;
        last  = '0;
        limit = (exp_lat == 0) ? 4 : exp_lat + 8;
        i_cmd    = cmd;
        i_addr   = addr;
        i_len    = len;
        i_cmd_en = 1'b1;
        while (!got && lat < limit) begin
            @(negedge clk);
            i_cmd_en = 1'b0;
            lat++;
            if (o_ack) got = 1'b1;
        end
        check({name, "_ack_lat"}, got ? 32'(lat) : 32'd0, 32'(exp_lat));
        if (got) begin
            if (cmd == C_WR) begin
                for (int k = 0; k <= int'(len); k++) begin
                    if (k > 0) @(negedge clk);
                    i_data = dbase + 32'(k);
                    i_dqm  = dqm;
                    model_write(addr, k, dbase + 32'(k), dqm);
                end
                @(negedge clk);
            end else if (cmd == C_RD) begin
                if (chk_data) begin
                    for (int k = 0; k <= int'(len); k++) sb_q.push_back(model[midx(addr, k)]);
                end
                for (int k = 0; k <= int'(len); k++) begin
                    repeat ((k == 0) ? CAS_LAT : 1) @(negedge clk);
                    if (chk_data) begin
                        if (sb_q.size() == 0) begin
                            check({name, "_sb_empty"}, 32'd1, 32'd0);
                        end else begin
                            last = sb_q.pop_front();
                            check($sformatf("%s_beat%0d", name, k), o_data, last);
                        end
                    end
                end
                @(negedge clk);
                if (chk_data) check({name, "_hold"}, o_data, last);
            end else begin
                @(negedge clk);
                check({name, "_ack_pulse"}, 32'(o_ack), 32'd0);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{C_ACT, ROW5,           8'd0, 32'h0,        4'b0000, 1};
        tbl[1]  = '{C_WR,  ROW5 | 21'h10,  8'd3, 32'hA0,       4'b0000, 1};
        tbl[2]  = '{C_RD,  ROW5 | 21'h10,  8'd3, 32'h0,        4'b0000, 1};
        tbl[3]  = '{C_WR,  ROW5 | 21'h20,  8'd0, 32'hFFFFFFFF, 4'b0000, 1};
        tbl[4]  = '{C_WR,  ROW5 | 21'h20,  8'd0, 32'h11223344, 4'b0101, 1};
        tbl[5]  = '{C_RD,  ROW5 | 21'h20,  8'd0, 32'h0,        4'b0000, 1};
        tbl[6]  = '{C_WR,  ROW5 | 21'hFE,  8'd3, 32'hB0,       4'b0000, 1};
        tbl[7]  = '{C_RD,  ROW5 | 21'h00,  8'd0, 32'h0,        4'b0000, 1};
        tbl[8]  = '{C_RD,  ROW5 | 21'hFE,  8'd3, 32'h0,        4'b0000, 1};
        tbl[9]  = '{C_NOP, ROW5,           8'd0, 32'h0,        4'b0000, 0};
        tbl[10] = '{3'b000, ROW5,          8'd0, 32'h0,        4'b0000, 0};
        tbl[11] = '{C_REF, ROW5,           8'd0, 32'h0,        4'b0000, REF_CYC + 1};
        tbl[12] = '{C_PRE, ROW5,           8'd0, 32'h0,        4'b0000, 1};

        reset_and_init("por");

        for (int i = 0; i < 13; i++) begin
            run_cmd($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].addr, tbl[i].len,
                    tbl[i].dbase, tbl[i].dqm, tbl[i].exp_lat, 1'b1);
        end
        check("perr_after_legal_traffic", 32'(o_perr), 32'd0);

        i_pd = 1'b1;
        run_cmd("power_down_block", C_ACT, BANK1, 8'd0, 32'h0, 4'b0000, 0, 1'b0);
        i_pd = 1'b0;
        i_sr = 1'b1;
        run_cmd("selfrefresh_block", C_ACT, BANK1, 8'd0, 32'h0, 4'b0000, 0, 1'b0);
        i_sr = 1'b0;
        check("perr_after_blocked", 32'(o_perr), 32'd0);

        run_cmd("read_no_activate", C_RD, BANK1, 8'd0, 32'h0, 4'b0000, 1, 1'b0);
        check("perr_set", 32'(o_perr), 32'(EXP_PERR));
        run_cmd("refresh_after_err", C_REF, BANK1, 8'd0, 32'h0, 4'b0000, REF_CYC + 1, 1'b0);
        check("perr_sticky", 32'(o_perr), 32'(EXP_PERR));

        run_cmd("act_pre_reset", C_ACT, ROW5, 8'd0, 32'h0, 4'b0000, 1, 1'b0);
        run_cmd("prefill", C_WR, ROW5 | 21'h40, 8'd3, 32'hC0, 4'b0000, 1, 1'b0);

        i_cmd    = C_WR;
        i_addr   = ROW5 | 21'h40;
        i_len    = 8'd3;
        i_cmd_en = 1'b1;
        @(negedge clk);
        i_cmd_en = 1'b0;
        check("abort_ack", 32'(o_ack), 32'd1);
        i_data = 32'hD0;
        i_dqm  = 4'b0000;
        model_write(ROW5 | 21'h40, 0, 32'hD0, 4'b0000);
        @(negedge clk);
        i_data = 32'hD1;
        model_write(ROW5 | 21'h40, 1, 32'hD1, 4'b0000);
        @(negedge clk);
        i_data = 32'hD2;
        reset_and_init("abort");

        run_cmd("act_post_reset", C_ACT, ROW5, 8'd0, 32'h0, 4'b0000, 1, 1'b0);
        run_cmd("abort_readback", C_RD, ROW5 | 21'h40, 8'd3, 32'h0, 4'b0000, 1, 1'b1);
        check("perr_after_reset", 32'(o_perr), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
